// File: rtl/uart_baud_generator.sv
// uart_baud_generator: fractional phase-accumulator baud tick generator with oversample phase counter
module uart_baud_generator #(
  parameter int ACC_WIDTH   = 16,
  parameter int OVERSAMPLE  = 16,
  parameter int DEFAULT_INC = 2416
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic                          resync,
  input  logic                          inc_load,
  input  logic [ACC_WIDTH-1:0]          inc_value,
  output logic                          tick_os,
  output logic                          tick_bit,
  output logic                          tick_half,
  output logic [$clog2(OVERSAMPLE)-1:0] phase,
  output logic                          load_err
);
  localparam int PW = $clog2(OVERSAMPLE);
  if (OVERSAMPLE < 2 || OVERSAMPLE > 256 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_bad_os
    $error("OVERSAMPLE must be a power of two from 2 to 256");
  end
  logic [ACC_WIDTH-1:0] acc_q, acc_d, inc_q, inc_d;
  logic [PW-1:0]        phase_q, phase_d;
  logic                 tick_os_q, tick_os_d, tick_bit_q, tick_bit_d, tick_half_q, tick_half_d;
  logic                 load_err_q, load_err_d;
  logic [ACC_WIDTH:0]   sum;
  logic                 step;
  always_comb begin
    sum         = {1'b0, acc_q} + {1'b0, inc_q};
    step        = enable & ~resync & sum[ACC_WIDTH];
    acc_d       = resync ? '0 : enable ? sum[ACC_WIDTH-1:0] : acc_q;
    phase_d     = resync ? '0 : step ? phase_q + 1'b1 : phase_q;
    tick_os_d   = step;
    tick_bit_d  = step & (phase_q == PW'(OVERSAMPLE - 1));
    tick_half_d = step & (phase_q == PW'(OVERSAMPLE / 2 - 1));
    load_err_d  = inc_load & (inc_value == '0);
    inc_d       = (inc_load && inc_value != '0) ? inc_value : inc_q;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_q       <= '0;
      inc_q       <= ACC_WIDTH'(DEFAULT_INC);
      phase_q     <= '0;
      tick_os_q   <= 1'b0;
      tick_bit_q  <= 1'b0;
      tick_half_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      inc_q       <= inc_d;
      phase_q     <= phase_d;
      tick_os_q   <= tick_os_d;
      tick_bit_q  <= tick_bit_d;
      tick_half_q <= tick_half_d;
      load_err_q  <= load_err_d;
    end
  end
  assign tick_os   = tick_os_q;
  assign tick_bit  = tick_bit_q;
  assign tick_half = tick_half_q;
  assign phase     = phase_q;
  assign load_err  = load_err_q;
endmodule
